// File: rtl/rgb_to_gray_if.sv
// Stream port bundle for rgb_to_gray: start/done handshake plus the source
// (read) and destination (write) BRAM ports.
interface rgb_to_gray_if;
  logic        start;
  logic        done;
  logic [31:0] src_addr;
  logic [31:0] src_dout;
  logic        src_en;
  logic [31:0] dst_addr;
  logic [31:0] dst_din;
  logic [3:0]  dst_we;

  modport master (
    input  start, src_dout,
    output done, src_addr, src_en, dst_addr, dst_din, dst_we
  );

  modport slave (
    output start, src_dout,
    input  done, src_addr, src_en, dst_addr, dst_din, dst_we
  );
endinterface

// File: rtl/rgb_to_gray.sv
// RGB-to-luma frame converter feeding the Sobel core; one pixel per 32-bit word.
// Optional build macro GRAY_ROUND_EN: round to nearest instead of truncating.
module rgb_to_gray #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int ADDR_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  rgb_to_gray_if.master bus
);

  localparam logic [31:0] N    = 32'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [31:0] LAST = N - 32'd1;
  localparam logic [31:0] STEP = 32'(ADDR_STEP);
`ifdef GRAY_ROUND_EN
  localparam logic [16:0] ROUND = 17'd128;
`else
  localparam logic [16:0] ROUND = 17'd0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic        src_en, done, launch, last_addr;
  logic [31:0] idx, widx, src_addr_q, dst_addr_q, dst_din_q;
  logic [2:0]  valid;
  logic [15:0] pr, pg, pb;
  logic [16:0] sum;
  logic [8:0]  unused_bits;

  assign launch      = (state == IDLE) && bus.start;
  assign last_addr   = (idx == LAST);
  assign sum         = {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + ROUND;
  assign unused_bits = {bus.src_dout[31:24], sum[16]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // DRAIN ends when only the final write is left in the pipe.
  always_comb begin
    state_next = state;
    src_en     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN: begin
        src_en = 1'b1;
        if (last_addr) state_next = DRAIN;
      end
      DRAIN:   if (valid == 3'b100) state_next = DONE;
      DONE: begin
        done = 1'b1;
        if (!bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // idx is the index currently on src_addr; address 0 is loaded on launch.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      idx        <= 32'd0;
      src_addr_q <= 32'd0;
    end else if (state == RUN && !last_addr) begin
      idx        <= idx + 32'd1;
      src_addr_q <= (idx + 32'd1) * STEP;
    end else begin
      src_addr_q <= 32'd0;
    end
  end

  // valid[0]: src_dout holds a pixel; valid[1]: products held; valid[2]: write out.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 3'b000;
      pr         <= 16'd0;
      pg         <= 16'd0;
      pb         <= 16'd0;
      widx       <= 32'd0;
      dst_addr_q <= 32'd0;
      dst_din_q  <= 32'd0;
    end else begin
      valid <= {valid[1:0], state == RUN};
      if (valid[0]) begin
        pr <= 16'd77  * {8'd0, bus.src_dout[23:16]};
        pg <= 16'd150 * {8'd0, bus.src_dout[15:8]};
        pb <= 16'd29  * {8'd0, bus.src_dout[7:0]};
      end
      if (launch) begin
        widx <= 32'd0;
      end else if (valid[1]) begin
        widx <= widx + 32'd1;
      end
      if (valid[1]) begin
        dst_din_q  <= {24'd0, sum[15:8]};
        dst_addr_q <= widx * STEP;
      end else begin
        dst_din_q  <= 32'd0;
      end
    end
  end

  assign bus.src_en   = src_en;
  assign bus.done     = done;
  assign bus.src_addr = src_addr_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_din  = dst_din_q;
  assign bus.dst_we   = {4{valid[2]}};

endmodule

// File: tb/tb_rgb_to_gray.sv
// Scoreboard bench for rgb_to_gray on a 4x4 frame: random pixels, a luma
// reference model, timing, reset-abort and start/done handshake checks.
module tb_rgb_to_gray;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;
`ifdef GRAY_ROUND_EN
  localparam int RND = 128;
  localparam int EXP_R = 77;
  localparam int EXP_B = 29;
`else
  localparam int RND = 0;
  localparam int EXP_R = 76;
  localparam int EXP_B = 28;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] src_mem [NPIX];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails = 0;
  int          writes_seen = 0;
  bit          ok;

  rgb_to_gray_if bus ();

  rgb_to_gray #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source BRAM model: one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.src_en) bus.src_dout <= src_mem[bus.src_addr[5:2]];
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int ref_gray(input logic [31:0] px);
    int r, g, b;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    return (77 * r + 150 * g + 29 * b + RND) / 256;
  endfunction

  task automatic push_expected(input bit directed);
    exp_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.addr = 32'(i * 4);
      if (directed && i == 0)      e.data = 32'h0000_00FF;
      else if (directed && i == 1) e.data = 32'h0000_0000;
      else if (directed && i == 2) e.data = 32'(EXP_R);
      else if (directed && i == 3) e.data = 32'd149;
      else if (directed && i == 4) e.data = 32'(EXP_B);
      else                         e.data = 32'(ref_gray(src_mem[i]));
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input bit directed);
    for (int i = 0; i < NPIX; i++) src_mem[i] = $urandom;
    if (directed) begin
      src_mem[0] = 32'h00FF_FFFF;
      src_mem[1] = 32'h0000_0000;
      src_mem[2] = 32'h00FF_0000;
      src_mem[3] = 32'h0000_FF00;
      src_mem[4] = 32'h0000_00FF;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("done_reached", {31'd0, bus.done}, 32'd1);
  endtask

  // Monitor: every write is popped against the scoreboard.
  always @(negedge clk) begin
    if (bus.dst_we !== 4'h0) begin
      writes_seen++;
      check_output("dst_we_value", {28'd0, bus.dst_we}, 32'h0000_000F);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 bus.dst_addr, bus.dst_din);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("dst_addr", bus.dst_addr, mon_e.addr);
        check_output("dst_din", bus.dst_din, mon_e.data);
      end
    end else if (!rst) begin
      check_output("idle_dst_din", bus.dst_din, 32'd0);
    end
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < NPIX; i++) src_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_output("rst_done", {31'd0, bus.done}, 32'd0);
    check_output("rst_src_en", {31'd0, bus.src_en}, 32'd0);
    check_output("rst_dst_we", {28'd0, bus.dst_we}, 32'd0);
    check_output("rst_src_addr", bus.src_addr, 32'd0);
    check_output("rst_dst_addr", bus.dst_addr, 32'd0);
    check_output("rst_dst_din", bus.dst_din, 32'd0);

    $display("[TB] frame 1: directed colours plus random pixels");
    apply_stimulus(1'b1);
    push_expected(1'b1);
    writes_seen = 0;
    pulse_start();
    check_output("first_src_en", {31'd0, bus.src_en}, 32'd1);
    check_output("first_src_addr", bus.src_addr, 32'd0);
    @(negedge clk);
    check_output("src_addr_1", bus.src_addr, 32'd4);
    @(negedge clk);
    check_output("no_early_write", {28'd0, bus.dst_we}, 32'd0);
    @(negedge clk);
    check_output("first_write_we", {28'd0, bus.dst_we}, 32'h0000_000F);
    check_output("first_write_addr", bus.dst_addr, 32'd0);
    wait_done(200);
    check_output("frame1_writes", 32'(writes_seen), 32'(NPIX));
    check_output("frame1_queue_empty", 32'(exp_q.size()), 32'd0);

    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("done_held", {31'd0, bus.done}, 32'd1);
    end
    check_output("no_writes_in_done", 32'(writes_seen), 32'(NPIX));
    bus.start = 1'b0;
    @(negedge clk);
    check_output("idle_done", {31'd0, bus.done}, 32'd0);
    check_output("idle_src_en", {31'd0, bus.src_en}, 32'd0);

    $display("[TB] frame 2: same image again");
    push_expected(1'b1);
    writes_seen = 0;
    pulse_start();
    check_output("f2_src_addr", bus.src_addr, 32'd0);
    wait_done(200);
    check_output("frame2_writes", 32'(writes_seen), 32'(NPIX));
    check_output("frame2_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] frame 3: random image aborted by reset at idx 7");
    @(negedge clk);
    apply_stimulus(1'b0);
    push_expected(1'b0);
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (bus.src_en === 1'b1 && bus.src_addr === 32'd28) ok = 1'b1;
      else @(negedge clk);
    end
    check_output("reach_idx7", bus.src_addr, 32'd28);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("abort_dst_we", {28'd0, bus.dst_we}, 32'd0);
    check_output("abort_src_en", {31'd0, bus.src_en}, 32'd0);
    check_output("abort_done", {31'd0, bus.done}, 32'd0);
    check_output("abort_src_addr", bus.src_addr, 32'd0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check_output("abort_no_writes", {28'd0, bus.dst_we}, 32'd0);

    $display("[TB] frame 4: rerun random image after abort");
    push_expected(1'b0);
    writes_seen = 0;
    pulse_start();
    check_output("f4_src_addr", bus.src_addr, 32'd0);
    wait_done(200);
    check_output("frame4_writes", 32'(writes_seen), 32'(NPIX));
    check_output("frame4_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
